result_page_scanner: RTL and testbench

- Parametrised successor to the ALU result display stage.
- Captures an ALU result word and its flags into a snapshot register on a load strobe.
- Presents the snapshot on an 8-bit LED bank one page at a time: each data byte is a page, plus one flag page.
- Pages are chosen manually by switch or stepped automatically on a programmable dwell timer. Sits between the ALU and the board LEDs.

---
 rtl/result_page_scanner.sv | 78 +++++++
 tb/tb_result_page_scanner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/result_page_scanner.sv
// Result page scanner: snapshots an ALU result and its flags, then pages the
// snapshot onto an 8-bit LED bank, either by switch or on an auto-scan timer.
module result_page_scanner #(
  parameter int DATA_W = 32,
  parameter int DWELL  = 50000000,
  localparam int NPAGE = DATA_W / 8 + 1,
  localparam int SEL_W = $clog2(NPAGE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] F,
  input  logic              OF,
  input  logic              ZF,
  input  logic              CF,
  input  logic              SF,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  output logic [7:0]        LED,
  output logic [SEL_W-1:0]  page
);

  localparam int NBYTE = DATA_W / 8;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_PAGE = SEL_W'(NPAGE - 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DWELL - 1);

  logic [DATA_W-1:0] data_q;
  logic [3:0]        flags_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [SEL_W-1:0]  page_d;
  logic [7:0]        led_d;

  // Snapshot, dwell counter, page and LED registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
      page    <= '0;
      LED     <= '0;
    end else begin
      if (load) begin
        data_q  <= F;
        flags_q <= {OF, ZF, CF, SF};
      end
      cnt_q <= cnt_d;
      page  <= page_d;
      LED   <= led_d;
    end
  end

  // Manual mode saturates the request onto the flag page and parks the
  // counter at zero, so a switch to auto always starts with a full dwell.
  always_comb begin
    cnt_d  = '0;
    page_d = page;
    if (mode) begin
      if (cnt_q == LAST_CNT) begin
        page_d = (page == LAST_PAGE) ? '0 : page + SEL_W'(1);
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      page_d = (sel > LAST_PAGE) ? LAST_PAGE : sel;
    end
  end

  // Decode the current page; anything that is not a byte page shows flags
  always_comb begin
    led_d = {flags_q[2], flags_q[0], flags_q[1], 4'b0000, flags_q[3]};
    for (int p = 0; p < NBYTE; p++) begin
      if (page == SEL_W'(p)) led_d = data_q[8*p +: 8];
    end
  end

endmodule

// File: tb/tb_result_page_scanner.sv
// Testbench for result_page_scanner: a 32-bit/DWELL=4 instance and an
// 8-bit/DWELL=1 instance, both checked against a page-level reference model.
module tb_result_page_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        load_a = 0, of_a = 0, zf_a = 0, cf_a = 0, sf_a = 0, mode_a = 0;
  logic [31:0] f_a = '0;
  logic [2:0]  sel_a = '0;
  logic [7:0]  led_a;
  logic [2:0]  page_a;

  logic        load_b = 0, of_b = 0, zf_b = 0, cf_b = 0, sf_b = 0, mode_b = 0;
  logic [7:0]  f_b = '0;
  logic [0:0]  sel_b = '0;
  logic [7:0]  led_b;
  logic [0:0]  page_b;

  int errors = 0;
  int checks = 0;

  result_page_scanner #(.DATA_W(32), .DWELL(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(load_a), .F(f_a),
    .OF(of_a), .ZF(zf_a), .CF(cf_a), .SF(sf_a),
    .mode(mode_a), .sel(sel_a), .LED(led_a), .page(page_a)
  );

  result_page_scanner #(.DATA_W(8), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(load_b), .F(f_b),
    .OF(of_b), .ZF(zf_b), .CF(cf_b), .SF(sf_b),
    .mode(mode_b), .sel(sel_b), .LED(led_b), .page(page_b)
  );

  // Reference model state per instance (0 = wide, 1 = narrow)
  logic [31:0] m_data [2];
  bit          m_of [2], m_zf [2], m_cf [2], m_sf [2];
  int          m_page [2];
  int          m_cnt [2];
  logic [7:0]  m_led [2];

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_data[d] = '0;
      m_of[d] = 0; m_zf[d] = 0; m_cf[d] = 0; m_sf[d] = 0;
      m_page[d] = 0;
      m_cnt[d] = 0;
      m_led[d] = '0;
    end
  endtask

  // One clock edge of the display: LED shows the page held before the edge,
  // then the snapshot, dwell timer and page advance.
  task automatic model_step(input int d, input int nbyte, input int dwell,
                            input bit ld, input logic [31:0] f,
                            input bit o, input bit z, input bit c, input bit s,
                            input bit md, input int req);
    int flag_val;
    flag_val = 128 * int'(m_zf[d]) + 64 * int'(m_sf[d]) + 32 * int'(m_cf[d]) + int'(m_of[d]);
    if (m_page[d] == nbyte) m_led[d] = 8'(flag_val);
    else                    m_led[d] = 8'((m_data[d] >> (8 * m_page[d])) % 256);
    if (ld) begin
      m_data[d] = f;
      m_of[d] = o; m_zf[d] = z; m_cf[d] = c; m_sf[d] = s;
    end
    if (md) begin
      m_cnt[d] = m_cnt[d] + 1;
      if (m_cnt[d] == dwell) begin
        m_cnt[d] = 0;
        m_page[d] = (m_page[d] + 1) % (nbyte + 1);
      end
    end else begin
      m_cnt[d] = 0;
      m_page[d] = (req > nbyte) ? nbyte : req;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, "/led_a"}, {24'b0, led_a}, {24'b0, m_led[0]});
    check({tag, "/page_a"}, {29'b0, page_a}, 32'(m_page[0]));
    check({tag, "/led_b"}, {24'b0, led_b}, {24'b0, m_led[1]});
    check({tag, "/page_b"}, {31'b0, page_b}, 32'(m_page[1]));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst_n) begin
      model_step(0, 4, 4, load_a, f_a, of_a, zf_a, cf_a, sf_a, mode_a, int'(sel_a));
      model_step(1, 1, 1, load_b, {24'b0, f_b}, of_b, zf_b, cf_b, sf_b, mode_b, int'(sel_b));
    end
    #1;
    check_output(tag);
  endtask

  task automatic apply_stimulus();
    load_a = ($urandom_range(0, 3) == 0);
    f_a    = $urandom;
    {of_a, zf_a, cf_a, sf_a} = 4'($urandom);
    mode_a = ($urandom_range(0, 9) < 7);
    sel_a  = 3'($urandom);
    load_b = ($urandom_range(0, 3) == 0);
    f_b    = 8'($urandom);
    {of_b, zf_b, cf_b, sf_b} = 4'($urandom);
    mode_b = ($urandom_range(0, 9) < 6);
    sel_b  = 1'($urandom);
  endtask

  logic [7:0] exp_bytes [6];
  logic [2:0] sel_list [6];

  initial begin
    model_reset();
    $display("[TB] reset hold");
    for (int i = 0; i < 4; i++) begin
      load_a = ~load_a; f_a = $urandom; mode_a = ~mode_a;
      load_b = ~load_b; f_b = 8'($urandom); mode_b = ~mode_b;
      tick("reset_hold");
    end
    load_a = 0; mode_a = 0; sel_a = 0; load_b = 0; mode_b = 0; sel_b = 0;
    rst_n = 1'b1;
    #1;
    check_output("release_no_edge");

    $display("[TB] manual paging");
    f_a = 32'hA1B2C3D4; {of_a, zf_a, cf_a, sf_a} = 4'b1011; load_a = 1;
    tick("load_a");
    load_a = 0;
    exp_bytes = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h61, 8'h61};
    sel_list  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    for (int i = 0; i < 6; i++) begin
      sel_a = sel_list[i];
      tick("sel_page");
      tick("sel_led");
      check("manual_led", {24'b0, led_a}, {24'b0, exp_bytes[i]});
      check("manual_page", {29'b0, page_a}, (i == 5) ? 32'd4 : 32'(i));
    end

    $display("[TB] load latency");
    sel_a = 1;
    tick("lat_sel"); tick("lat_sel2");
    f_a = 32'h0000FF00; load_a = 1;
    tick("lat_k");
    check("lat_old_byte", {24'b0, led_a}, 32'hC3);
    load_a = 0;
    tick("lat_k1");
    check("lat_new_byte", {24'b0, led_a}, 32'hFF);

    $display("[TB] auto scan with wrap");
    sel_a = 3;
    tick("to_p3");
    mode_a = 1;
    for (int i = 1; i <= 12; i++) begin
      tick("auto");
      if (i == 3)  check("auto_hold3", {29'b0, page_a}, 32'd3);
      if (i == 4)  check("auto_p4", {29'b0, page_a}, 32'd4);
      if (i == 8)  check("auto_wrap0", {29'b0, page_a}, 32'd0);
      if (i == 12) check("auto_p1", {29'b0, page_a}, 32'd1);
    end
    tick("mid1"); tick("mid2");
    mode_a = 0; sel_a = 2;
    tick("drop_manual");
    check("drop_page2", {29'b0, page_a}, 32'd2);
    mode_a = 1;
    for (int i = 1; i <= 4; i++) begin
      tick("reraise");
      if (i == 3) check("reraise_hold", {29'b0, page_a}, 32'd2);
      if (i == 4) check("reraise_adv", {29'b0, page_a}, 32'd3);
    end

    $display("[TB] narrow instance, DWELL=1");
    f_b = 8'h5A; {of_b, zf_b, cf_b, sf_b} = 4'b0101; load_b = 1; mode_b = 0; sel_b = 0;
    tick("b_load");
    load_b = 0; mode_b = 1;
    for (int i = 0; i < 4; i++) tick("b_toggle");
    f_b = 8'h3C; {of_b, zf_b, cf_b, sf_b} = 4'b1000; load_b = 1;
    tick("b_load_adv");
    load_b = 0;
    tick("b_load_k1");
    check("b_new_snapshot", {24'b0, led_b}, (m_page[1] == 1) ? 32'h3C : 32'h01);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      apply_stimulus();
      tick("random");
    end

    $display("[TB] reset mid-scan");
    load_a = 0; mode_a = 1; load_b = 0; mode_b = 1;
    for (int i = 0; i < 30 && m_page[0] != 3; i++) tick("seek_p3");
    check("reach_p3", {29'b0, page_a}, 32'd3);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check_output("async_reset");
    check("async_led0", {24'b0, led_a}, 32'h0);
    #3 rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick("restart");
      if (i == 3) check("restart_hold0", {29'b0, page_a}, 32'd0);
      if (i == 4) check("restart_p1", {29'b0, page_a}, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
